// File: rtl/tb_mmio_irq_gen_pkg.sv
// Register offsets, timer states and byte-merge helper shared by the
// interrupt-injection MMIO peripheral and its timer.
package tb_mmio_irq_gen_pkg;

  // Word offsets within the 16-byte window (addr[3:2])
  localparam logic [1:0] IRQ_CTRL_OFS = 2'd0;
  localparam logic [1:0] IRQ_CLR_OFS  = 2'd1;
  localparam logic [1:0] TOHOST_OFS   = 2'd2;
  localparam logic [1:0] CYCLES_OFS   = 2'd3;

  localparam int unsigned EN_BIT       = 16;
  localparam int unsigned PERIODIC_BIT = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } tmr_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tb_irq_timer.sv
// One-shot / periodic interrupt timer: down-counter, state machine and the
// irq level, steered by load/disable/clear strobes from the bus decode.
module tb_irq_timer
  import tb_mmio_irq_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        dis_i,
  input  logic        clr_i,
  input  logic [15:0] delay_i,
  input  logic        periodic_i,
  output logic [1:0]  state_o,
  output logic        irq_o
);

  tmr_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;
  logic        fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      COUNT: begin
        if (cnt_q == 16'd0) begin
          fire = 1'b1;
          if (periodic_i) cnt_d = delay_i;
          else            state_d = FIRED;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      FIRED: if (clr_i) state_d = IDLE;
      default: ;
    endcase

    if (dis_i) begin
      state_d = IDLE;
      fire    = 1'b0;
    end

    // The load edge itself is the first counted cycle, so DELAY=d lands
    // the irq at grant+d+1; DELAY=0 fires straight off the load edge.
    if (load_i) begin
      if (delay_i == 16'd0) begin
        fire    = 1'b1;
        state_d = periodic_i ? COUNT : FIRED;
        cnt_d   = 16'd0;
      end else begin
        fire    = 1'b0;
        state_d = COUNT;
        cnt_d   = delay_i - 16'd1;
      end
    end

    // A fire beats a simultaneous clear; a fire while high is not queued
    irq_d = fire | (irq_q & ~clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign state_o = state_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/tb_mmio_irq_gen.sv
// Bench-side MMIO peripheral: interrupt injection timer, free-running cycle
// counter and end-of-test mailbox behind a zero-wait req/gnt/rvalid port.
module tb_mmio_irq_gen
  import tb_mmio_irq_gen_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2100_0600,
  parameter int          DW        = 33
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          data_req_i,
  input  logic [31:0]   data_addr_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [DW-1:0] data_rdata_o,
  output logic          data_err_o,
  output logic          irq_o,
  output logic          done_o,
  output logic [31:0]   done_code_o
);

  logic        hit, wr, rd;
  logic [1:0]  wsel;
  logic [31:0] wdata32;
  logic        ctrl_wr, clr_wr, tohost_wr;
  logic [31:0] ctrl_wval;

  logic [17:0]   ctrl_q, ctrl_d;
  logic [31:0]   code_q, code_d;
  logic          done_q, done_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          tmr_load, tmr_dis;
  logic [1:0]    tmr_state;
  logic          tmr_irq;

  // Capability tag and sub-word address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{data_wdata_i[DW-1:32], data_addr_i[1:0], ctrl_wval[31:18]};

  assign hit       = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign wsel      = data_addr_i[3:2];
  assign wr        = hit &  data_we_i;
  assign rd        = hit & ~data_we_i;
  assign wdata32   = data_wdata_i[31:0];
  assign ctrl_wr   = wr && (wsel == IRQ_CTRL_OFS);
  assign clr_wr    = wr && (wsel == IRQ_CLR_OFS);
  assign tohost_wr = wr && (wsel == TOHOST_OFS);
  assign ctrl_wval = be_merge({14'd0, ctrl_q}, wdata32, data_be_i);

  assign tmr_load = ctrl_wr &  ctrl_wval[EN_BIT];
  assign tmr_dis  = ctrl_wr & ~ctrl_wval[EN_BIT];

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = ctrl_wval[17:0];
    // Acknowledging a finished one-shot also disarms it
    if (clr_wr && (tmr_state == FIRED)) ctrl_d[EN_BIT] = 1'b0;

    code_d   = tohost_wr ? be_merge(code_q, wdata32, data_be_i) : code_q;
    done_d   = tohost_wr;
    cycles_d = cycles_q + 32'd1;

    rvalid_d = hit;
    err_d    = (rd && (data_be_i == 4'd0)) ||
               (wr && (wsel == CYCLES_OFS) && (data_be_i == 4'd0));

    rdata_d = '0;
    if (rd && !err_d) begin
      case (wsel)
        IRQ_CTRL_OFS: rdata_d[31:0] = {11'd0, tmr_irq, tmr_state, ctrl_q};
        TOHOST_OFS:   rdata_d[31:0] = code_q;
        CYCLES_OFS:   rdata_d[31:0] = cycles_q;
        default:      rdata_d[31:0] = 32'd0;
      endcase
    end
  end

  // Response stage: one cycle after the grant cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      code_q   <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      code_q   <= code_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Timer sees the post-write DELAY/PERIODIC so a load uses the new values
  tb_irq_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .dis_i      (tmr_dis),
    .clr_i      (clr_wr),
    .delay_i    (ctrl_d[15:0]),
    .periodic_i (ctrl_d[PERIODIC_BIT]),
    .state_o    (tmr_state),
    .irq_o      (tmr_irq)
  );

  assign data_gnt_o    = hit;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign irq_o         = tmr_irq;
  assign done_o        = done_q;
  assign done_code_o   = code_q;

endmodule

// File: tb/tb_tb_mmio_irq_gen.sv
// Scoreboard bench for tb_mmio_irq_gen: expected responses are queued when a
// request is granted and popped when the response cycle arrives.
module tb_tb_mmio_irq_gen;

  localparam int          DW   = 33;
  localparam logic [31:0] BASE = 32'h2100_0600;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_req_i = 1'b0;
  logic [31:0]   data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] data_rdata_o;
  logic          irq_o, done_o;
  logic [31:0]   done_code_o;

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    logic        approx;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc;

  tb_mmio_irq_gen #(.BASE_ADDR(BASE), .DW(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .irq_o         (irq_o),
    .done_o        (done_o),
    .done_code_o   (done_code_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: clock edges seen since reset was released
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    data_req_i = 1'b1; data_we_i = w; data_addr_i = a; data_be_i = b;
    data_wdata_i = {1'b0, d};
  endtask

  task automatic release_bus();
    data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_be_i = '0;
    data_wdata_i = '0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic er, input logic ap);
    exp_t e;
    e.rdata = {1'b0, d}; e.err = er; e.approx = ap;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   diff;
    release_bus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, irq_o, done_o, done_code_o} !== '0) begin
      bad++; $display("FAIL reset_hold: got rv=%b rd=%h irq=%b done=%b code=%h want all 0",
                      data_rvalid_o, data_rdata_o, irq_o, done_o, done_code_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, irq_o, done_o, done_code_o} !== '0) begin
        bad++; $display("FAIL idle_%0d: got rv=%b rd=%h irq=%b done=%b want all 0",
                        i, data_rvalid_o, data_rdata_o, irq_o, done_o);
      end
    end
    drive(1'b0, BASE + 32'hC, 4'hF, 32'd0);
    push_exp(cyc, 1'b0, 1'b1);
    @(negedge clk);
    release_bus();
    e = sb.pop_front(); total++;
    diff = $signed(data_rdata_o[31:0] - e.rdata[31:0]);
    if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0 || diff > 2 || diff < -2) begin
      bad++; $display("FAIL cycles_after_reset: got rv=%b rd=%h want rv=1 rd~%h",
                      data_rvalid_o, data_rdata_o, e.rdata);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    @(negedge clk);
    drive(1'b1, BASE, 4'hF, 32'h0001_0005);
    push_exp(32'd0, 1'b0, 1'b0);
    #1; total++;
    if (data_gnt_o !== 1'b1) begin bad++; $display("FAIL oneshot_gnt: got %b want 1", data_gnt_o); end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin
        release_bus();
        e = sb.pop_front(); total++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || data_err_o !== e.err) begin
          bad++; $display("FAIL oneshot_wr_resp: got rv=%b rd=%h err=%b want rv=1 rd=%h err=%b",
                          data_rvalid_o, data_rdata_o, data_err_o, e.rdata, e.err);
        end
      end
      total++;
      if (irq_o !== (j >= 6)) begin
        bad++; $display("FAIL oneshot_irq_t%0d: got %b want %b", j, irq_o, (j >= 6));
      end
    end
    // Read state, clear, read again; each step back to back
    drive(1'b0, BASE, 4'hF, 32'd0);
    push_exp(32'h0019_0005, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || data_err_o !== e.err) begin
        bad++; $display("FAIL oneshot_seq_%0d: got rv=%b rd=%h err=%b want rv=1 rd=%h err=%b",
                        k, data_rvalid_o, data_rdata_o, data_err_o, e.rdata, e.err);
      end
      if (k == 0) begin
        drive(1'b1, BASE + 32'h4, 4'hF, 32'd0); push_exp(32'd0, 1'b0, 1'b0);
      end else if (k == 1) begin
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL oneshot_clr_irq: got %b want 0", irq_o); end
        drive(1'b0, BASE, 4'hF, 32'd0); push_exp(32'h0000_0005, 1'b0, 1'b0);
      end else release_bus();
    end
    // DELAY=0 fires the cycle right after the grant
    @(negedge clk);
    drive(1'b1, BASE, 4'hF, 32'h0001_0000); push_exp(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || data_err_o !== e.err) begin
      bad++; $display("FAIL d0_resp: got rv=%b rd=%h want rv=1 rd=%h", data_rvalid_o, data_rdata_o, e.rdata);
    end
    total++;
    if (irq_o !== 1'b1) begin bad++; $display("FAIL d0_irq: got %b want 1", irq_o); end
    drive(1'b1, BASE + 32'h4, 4'hF, 32'd0); push_exp(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    release_bus();
    e = sb.pop_front(); total++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || irq_o !== 1'b0) begin
      bad++; $display("FAIL d0_clr: got rv=%b rd=%h irq=%b want rv=1 rd=%h irq=0",
                      data_rvalid_o, data_rdata_o, irq_o, e.rdata);
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    logic pend, exp_irq;
    @(negedge clk);
    drive(1'b1, BASE, 4'hF, 32'h0003_0003); push_exp(32'd0, 1'b0, 1'b0);
    pend = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (pend) begin
        e = sb.pop_front(); total++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || data_err_o !== e.err) begin
          bad++; $display("FAIL per_resp_t%0d: got rv=%b rd=%h want rv=1 rd=%h",
                          j, data_rvalid_o, data_rdata_o, e.rdata);
        end
      end
      // Fires visible every 4th cycle; the clear at t11 collides with a fire
      exp_irq = ((j % 4) == 0) || (j >= 12);
      total++;
      if (irq_o !== exp_irq) begin bad++; $display("FAIL per_irq_t%0d: got %b want %b", j, irq_o, exp_irq); end
      if (j == 4 || j == 8 || j == 11) begin
        drive(1'b1, BASE + 32'h4, 4'hF, 32'd0); push_exp(32'd0, 1'b0, 1'b0); pend = 1'b1;
      end else begin
        release_bus(); pend = 1'b0;
      end
    end
    // Disabling leaves irq up until an explicit clear
    drive(1'b1, BASE, 4'hF, 32'h0000_1234); push_exp(32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || data_err_o !== e.err) begin
        bad++; $display("FAIL per_dis_seq_%0d: got rv=%b rd=%h want rv=1 rd=%h",
                        k, data_rvalid_o, data_rdata_o, e.rdata);
      end
      if (k == 0) begin
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL per_dis_irq: got %b want 1", irq_o); end
        drive(1'b0, BASE, 4'hF, 32'd0); push_exp(32'h0010_1234, 1'b0, 1'b0);
      end else if (k == 1) begin
        drive(1'b1, BASE + 32'h4, 4'hF, 32'd0); push_exp(32'd0, 1'b0, 1'b0);
      end else begin
        release_bus(); total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL per_final_clr: got %b want 0", irq_o); end
      end
    end
  endtask

  task automatic test_tohost();
    exp_t e;
    @(negedge clk);
    drive(1'b1, BASE + 32'h8, 4'b0011, 32'hCAFE_0001); push_exp(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    release_bus();
    e = sb.pop_front(); total++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || done_o !== 1'b1 || done_code_o !== 32'h0000_0001) begin
      bad++; $display("FAIL tohost_lo: got rv=%b done=%b code=%h want rv=1 done=1 code=00000001",
                      data_rvalid_o, done_o, done_code_o);
    end
    @(negedge clk);
    total++;
    if (done_o !== 1'b0) begin bad++; $display("FAIL tohost_pulse: got done=%b want 0", done_o); end
    drive(1'b1, BASE + 32'h8, 4'b1100, 32'hBEEF_0000); push_exp(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    e = sb.pop_front(); total++;
    if (data_rvalid_o !== 1'b1 || done_o !== 1'b1 || done_code_o !== 32'hBEEF_0001) begin
      bad++; $display("FAIL tohost_hi: got rv=%b done=%b code=%h want rv=1 done=1 code=beef0001",
                      data_rvalid_o, done_o, done_code_o);
    end
    drive(1'b0, BASE + 32'hB, 4'hF, 32'd0); push_exp(32'hBEEF_0001, 1'b0, 1'b0);
    @(negedge clk);
    release_bus();
    e = sb.pop_front(); total++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== e.rdata || done_o !== 1'b0) begin
      bad++; $display("FAIL tohost_read: got rv=%b rd=%h done=%b want rv=1 rd=%h done=0",
                      data_rvalid_o, data_rdata_o, done_o, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          diff;
    logic        ow[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] oa[6]  = '{BASE + 32'hC, BASE, BASE, BASE + 32'hC, BASE + 32'hC, BASE + 32'hE};
    logic [3:0]  ob[6]  = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
    logic [31:0] od[6]  = '{32'd0, 32'd0, 32'd0, 32'd5, 32'h0000_FFFF, 32'd0};
    logic [31:0] oe[6]  = '{32'd0, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        oer[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        oap[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front(); total++;
        diff = $signed(data_rdata_o[31:0] - e.rdata[31:0]);
        if (data_rvalid_o !== 1'b1 || data_err_o !== e.err || data_rdata_o[32] !== 1'b0 ||
            (e.approx ? (diff > 2 || diff < -2) : (data_rdata_o !== e.rdata))) begin
          bad++; $display("FAIL b2b_resp_%0d: got rv=%b rd=%h err=%b want rv=1 rd=%h err=%b",
                          i - 1, data_rvalid_o, data_rdata_o, data_err_o, e.rdata, e.err);
        end
      end
      if (i < 6) begin
        drive(ow[i], oa[i], ob[i], od[i]);
        push_exp(oap[i] ? cyc : oe[i], oer[i], oap[i]);
        #1; total++;
        if (data_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt_%0d: got %b want 1", i, data_gnt_o); end
      end else begin
        release_bus();
      end
    end
  endtask

  task automatic test_out_of_window();
    @(negedge clk);
    drive(1'b0, 32'h2100_0610, 4'hF, 32'd0);
    #1; total++;
    if (data_gnt_o !== 1'b0) begin bad++; $display("FAIL oow_gnt_hi: got %b want 0", data_gnt_o); end
    @(negedge clk);
    total++;
    if (data_rvalid_o !== 1'b0) begin bad++; $display("FAIL oow_rv_hi: got %b want 0", data_rvalid_o); end
    drive(1'b1, 32'h2100_05FC, 4'hF, 32'hFFFF_FFFF);
    #1; total++;
    if (data_gnt_o !== 1'b0) begin bad++; $display("FAIL oow_gnt_lo: got %b want 0", data_gnt_o); end
    @(negedge clk);
    release_bus(); total++;
    if (data_rvalid_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL oow_rv_lo: got rv=%b done=%b want 0 0", data_rvalid_o, done_o);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive(1'b0, BASE + 32'hC, 4'hF, 32'd0);
    #1; total++;
    if (data_gnt_o !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", data_gnt_o); end
    #1 rst = 1'b1;
    #1 release_bus(); total++;
    if (done_code_o !== 32'd0 || irq_o !== 1'b0) begin
      bad++; $display("FAIL mid_async_code: got code=%h irq=%b want 0 0", done_code_o, irq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); total++;
      if (data_rvalid_o !== 1'b0) begin bad++; $display("FAIL mid_dropped_%0d: got rv=%b want 0", i, data_rvalid_o); end
    end
    // A response already on the bus vanishes as soon as reset rises
    drive(1'b0, BASE + 32'hC, 4'hF, 32'd0);
    @(negedge clk);
    release_bus(); total++;
    if (data_rvalid_o !== 1'b1) begin bad++; $display("FAIL mid_rv_before: got %b want 1", data_rvalid_o); end
    #2 rst = 1'b1;
    #1; total++;
    if (data_rvalid_o !== 1'b0 || data_rdata_o !== '0 || data_err_o !== 1'b0) begin
      bad++; $display("FAIL mid_async_rv: got rv=%b rd=%h err=%b want 0 0 0", data_rvalid_o, data_rdata_o, data_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); total++;
    if (data_rvalid_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL mid_after: got rv=%b done=%b want 0 0", data_rvalid_o, done_o);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_tohost();
    test_back_to_back();
    test_out_of_window();
    test_reset_midflight();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
